// File: rtl/uca_pkg.sv
// Shared types and constants for the unit-clause arbiter: literal type,
// sizing constants and the literal-to-variable helper.
package uca_pkg;

    localparam int unsigned NUM_ENGINE  = 4;
    localparam int unsigned LIT_IDX_MAX = 1023;
    localparam int unsigned QUEUE_DEPTH = 16;

    localparam int unsigned LW = $clog2(LIT_IDX_MAX) + 1;
    localparam int unsigned VW = $clog2(LIT_IDX_MAX + 1);
    localparam int unsigned EW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

    typedef logic signed [LW-1:0] lit_t;
    typedef logic [VW-1:0]        var_t;

    function automatic var_t lit_var(input lit_t l);
        lit_t a;
        a = l[LW-1] ? -l : l;
        return a[VW-1:0];
    endfunction

endpackage

// File: rtl/uca_fifo.sv
// Synchronous FIFO of literals; push/pop may coincide, including when full.
// The caller guarantees no push when full without a pop, and no pop when empty.
module uca_fifo
    import uca_pkg::*;
#(
    parameter int unsigned DEPTH = QUEUE_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  lit_t push_data,
    input  logic pop,
    output lit_t head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    lit_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uca_arbiter_wrap.sv
// Unit-clause arbiter: merges memory and engine unit literals into one FIFO with
// dedup/conflict detection. Define UCA_ROUND_ROBIN_EN for round-robin engine grant.
module uc_arbiter_wrap
  import uca_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem2uca_valid,
  input  logic                     mem2uca_done,
  input  logic signed [LW-1:0]     mem2uca,
  input  logic [NUM_ENGINE*LW-1:0] eng2uca_min,
  input  logic [NUM_ENGINE-1:0]    eng2uca_valid,
  input  logic [NUM_ENGINE-1:0]    eng2uca_empty,
  input  logic [NUM_ENGINE-1:0]    eng2uca_full,
  output logic signed [LW-1:0]     uca2eng,
  input  logic                     input_mode,
  output logic                     uca2eng_pop,
  output logic                     conflict
);

  localparam int unsigned TBL = LIT_IDX_MAX + 1;

  logic [TBL-1:0]        tbl_assigned;
  logic [TBL-1:0]        tbl_sign;
  logic                  done_q;
  logic                  conflict_q;

  lit_t                  eng_lit [NUM_ENGINE];
  logic [NUM_ENGINE-1:0] eng_req;
  logic                  eng_gnt_vld;
  logic [EW-1:0]         eng_gnt_idx;

  logic                  mem_sel;
  lit_t                  cand;
  logic                  cand_vld;
  var_t                  cand_var;
  logic                  cand_neg;
  logic                  cand_hit;
  logic                  conflict_set;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  lit_t                  fifo_head;

  // Heads already queued with the same polarity are masked out of arbitration,
  // so a held duplicate never blocks other engines under either grant scheme.
  always_comb begin
    eng_req = '0;
    for (int unsigned i = 0; i < NUM_ENGINE; i++) begin
      eng_lit[i] = eng2uca_min[i*LW +: LW];
      eng_req[i] = eng2uca_valid[i] && !eng2uca_empty[i] && (eng_lit[i] != '0)
        && !(tbl_assigned[lit_var(eng_lit[i])]
             && (tbl_sign[lit_var(eng_lit[i])] == eng_lit[i][LW-1]));
    end
  end

`ifdef UCA_ROUND_ROBIN_EN
  logic [EW-1:0] rr_ptr;

  always_comb begin
    eng_gnt_vld = 1'b0;
    eng_gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_ENGINE; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + k) % NUM_ENGINE;
      if (!eng_gnt_vld && eng_req[idx]) begin
        eng_gnt_vld = 1'b1;
        eng_gnt_idx = EW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (!mem_sel && eng_gnt_vld && !conflict_q) begin
      rr_ptr <= (eng_gnt_idx == EW'(NUM_ENGINE - 1)) ? '0 : eng_gnt_idx + EW'(1);
    end
  end
`else
  always_comb begin
    eng_gnt_vld = 1'b0;
    eng_gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_ENGINE; k++) begin
      if (!eng_gnt_vld && eng_req[k]) begin
        eng_gnt_vld = 1'b1;
        eng_gnt_idx = EW'(k);
      end
    end
  end
`endif

  assign mem_sel = input_mode && mem2uca_valid && !done_q;

  always_comb begin
    cand     = mem_sel ? lit_t'(mem2uca) : eng_lit[eng_gnt_idx];
    cand_vld = (mem_sel || eng_gnt_vld) && (cand != '0) && !conflict_q;
    cand_var = lit_var(cand);
    cand_neg = cand[LW-1];
    cand_hit = tbl_assigned[cand_var];
  end

  assign conflict_set = cand_vld && cand_hit && (tbl_sign[cand_var] != cand_neg);
  // A full FIFO accepts a push only when the head leaves in the same cycle.
  assign fifo_push    = cand_vld && !cand_hit && (!fifo_full || uca2eng_pop);
  assign uca2eng_pop  = !fifo_empty && !(|eng2uca_full) && !conflict_q;
  assign uca2eng      = fifo_empty ? '0 : fifo_head;
  assign conflict     = conflict_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q       <= 1'b0;
      conflict_q   <= 1'b0;
      tbl_assigned <= '0;
      tbl_sign     <= '0;
    end else begin
      if (mem2uca_done) done_q <= 1'b1;
      if (conflict_set) conflict_q <= 1'b1;
      if (fifo_push) begin
        tbl_assigned[cand_var] <= 1'b1;
        tbl_sign[cand_var]     <= cand_neg;
      end
    end
  end

  uca_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (fifo_push),
    .push_data (cand),
    .pop       (uca2eng_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uc_arbiter_wrap.sv
// Scoreboard bench for uc_arbiter_wrap: expected broadcast literals are queued
// when stimulus is driven and compared on every uca2eng_pop.
module tb_uc_arbiter_wrap;
  import uca_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     mem2uca_valid;
  logic                     mem2uca_done;
  logic signed [LW-1:0]     mem2uca;
  logic [NUM_ENGINE*LW-1:0] eng2uca_min;
  logic [NUM_ENGINE-1:0]    eng2uca_valid;
  logic [NUM_ENGINE-1:0]    eng2uca_empty;
  logic [NUM_ENGINE-1:0]    eng2uca_full;
  logic signed [LW-1:0]     uca2eng;
  logic                     input_mode;
  logic                     uca2eng_pop;
  logic                     conflict;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  uc_arbiter_wrap dut (
    .clk           (clk),
    .rst           (rst),
    .mem2uca_valid (mem2uca_valid),
    .mem2uca_done  (mem2uca_done),
    .mem2uca       (mem2uca),
    .eng2uca_min   (eng2uca_min),
    .eng2uca_valid (eng2uca_valid),
    .eng2uca_empty (eng2uca_empty),
    .eng2uca_full  (eng2uca_full),
    .uca2eng       (uca2eng),
    .input_mode    (input_mode),
    .uca2eng_pop   (uca2eng_pop),
    .conflict      (conflict)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_eng(input int idx, input lit_t val, input logic vld);
    eng2uca_min[idx*LW +: LW] = val;
    eng2uca_valid[idx]        = vld;
    eng2uca_empty[idx]        = !vld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    step();
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && uca2eng_pop) begin
      n_pop++;
      if (exp_q.size() == 0) check_eq("pop_unexpected", int'(uca2eng_pop), 0);
      else                   check_eq("pop_data", int'(uca2eng), exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vals[5];
    vals = '{10, 20, 30, 40, 50};
    rst           = 1'b0;
    mem2uca_valid = 1'b0;
    mem2uca_done  = 1'b0;
    mem2uca       = '0;
    eng2uca_min   = '0;
    eng2uca_valid = '0;
    eng2uca_empty = '1;
    eng2uca_full  = '0;
    input_mode    = 1'b0;
    #12;
    check_eq("rst_uca2eng", int'(uca2eng), 0);
    check_eq("rst_pop", int'(uca2eng_pop), 0);
    check_eq("rst_conflict", int'(conflict), 0);
    @(negedge clk);
    rst = 1'b1;

    // memory burst
    n_pop      = 0;
    input_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      mem2uca       = lit_t'(vals[i]);
      mem2uca_valid = 1'b1;
      exp_q.push_back(vals[i]);
    end
    step();
    mem2uca_valid = 1'b0;
    mem2uca       = '0;
    mem2uca_done  = 1'b1;
    step();
    mem2uca_done = 1'b0;
    repeat (3) step();
    check_eq("burst_pop_count", n_pop, 5);
    check_eq("burst_idle_data", int'(uca2eng), 0);
    check_eq("burst_idle_pop", int'(uca2eng_pop), 0);
    check_eq("burst_sb_empty", exp_q.size(), 0);

    // held engine heads, each enqueued once
    n_pop = 0;
    step();
    set_eng(1, lit_t'(3), 1'b1);
    set_eng(3, lit_t'(5), 1'b1);
    exp_q.push_back(3);
    exp_q.push_back(5);
    repeat (4) step();
    set_eng(1, '0, 1'b0);
    set_eng(3, '0, 1'b0);
    repeat (3) step();
    check_eq("heads_pop_count", n_pop, 2);
    check_eq("heads_idle_pop", int'(uca2eng_pop), 0);
    check_eq("heads_idle_data", int'(uca2eng), 0);

    // full stall
    n_pop = 0;
    step();
    eng2uca_full[2] = 1'b1;
    set_eng(0, lit_t'(60), 1'b1);
    exp_q.push_back(60);
    step();
    set_eng(0, '0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("stall_pop", int'(uca2eng_pop), 0);
      check_eq("stall_data", int'(uca2eng), 60);
    end
    step();
    eng2uca_full[2] = 1'b0;
    repeat (3) step();
    check_eq("stall_release_pops", n_pop, 1);

    // conflict
    do_reset();
    n_pop      = 0;
    input_mode = 1'b1;
    step();
    mem2uca       = lit_t'(7);
    mem2uca_valid = 1'b1;
    exp_q.push_back(7);
    step();
    mem2uca_valid = 1'b0;
    mem2uca       = '0;
    repeat (2) step();
    set_eng(0, lit_t'(-7), 1'b1);
    @(negedge clk);
    check_eq("conflict_before_edge", int'(conflict), 0);
    step();
    set_eng(0, '0, 1'b0);
    mem2uca       = lit_t'(8);
    mem2uca_valid = 1'b1;
    check_eq("conflict_set", int'(conflict), 1);
    step();
    mem2uca_valid = 1'b0;
    mem2uca       = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("conflict_sticky", int'(conflict), 1);
    end
    check_eq("conflict_pop_count", n_pop, 1);
    check_eq("conflict_no_pop", int'(uca2eng_pop), 0);

    // overflow with simultaneous push and pop
    do_reset();
    n_pop           = 0;
    input_mode      = 1'b0;
    eng2uca_full[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      set_eng(0, lit_t'(100 + i), 1'b1);
      exp_q.push_back(100 + i);
    end
    step();
    set_eng(0, '0, 1'b0);
    set_eng(1, lit_t'(99), 1'b1);
    repeat (3) step();
    @(negedge clk);
    check_eq("ovf_hold_pop", int'(uca2eng_pop), 0);
    check_eq("ovf_hold_head", int'(uca2eng), 100);
    step();
    eng2uca_full[0] = 1'b0;
    exp_q.push_back(99);
    step();
    set_eng(1, '0, 1'b0);
    repeat (20) step();
    check_eq("ovf_pop_count", n_pop, 17);
    check_eq("ovf_sb_empty", exp_q.size(), 0);

    // async reset mid-burst
    do_reset();
    n_pop           = 0;
    input_mode      = 1'b1;
    eng2uca_full[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      mem2uca       = lit_t'(i);
      mem2uca_valid = 1'b1;
    end
    step();
    mem2uca_valid = 1'b0;
    mem2uca       = '0;
    set_eng(2, lit_t'(-2), 1'b1);
    step();
    set_eng(2, '0, 1'b0);
    @(negedge clk);
    check_eq("arst_pre_conflict", int'(conflict), 1);
    check_eq("arst_pre_head", int'(uca2eng), 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_data", int'(uca2eng), 0);
    check_eq("arst_pop", int'(uca2eng_pop), 0);
    check_eq("arst_conflict", int'(conflict), 0);
    eng2uca_full[0] = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) step();
    check_eq("arst_empty_data", int'(uca2eng), 0);
    check_eq("arst_empty_pop", int'(uca2eng_pop), 0);
    mem2uca       = lit_t'(2);
    mem2uca_valid = 1'b1;
    exp_q.push_back(2);
    step();
    mem2uca_valid = 1'b0;
    mem2uca       = '0;
    repeat (3) step();
    check_eq("arst_table_cleared", n_pop, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uc_arbiter_wrap.md
Name: uc_arbiter_wrap

Overview:
Unit-clause arbiter (UCA) for the BCP engine array. It collects unit literals from the memory loader and from the per-engine minimum-literal heads into one FIFO, deduplicating and detecting conflicts as it goes. It broadcasts the FIFO head to all engines and pops the head only when no engine queue is full. It sits between the clause-memory loader and the NUM_ENGINE lookup engines.

Parameters:
NUM_ENGINE, 4, number of engines served.
LIT_IDX_MAX, 1023, largest variable index. Literal width LW = $clog2(LIT_IDX_MAX)+1, signed.
QUEUE_DEPTH, 16, depth of the unit-clause FIFO (power of two).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
mem2uca_valid  in  1  memory literal valid.
mem2uca_done  in  1  memory load finished (sticky once seen).
mem2uca  in  LW signed  literal from memory.
eng2uca_min  in  NUM_ENGINE x LW signed  per-engine head literal.
eng2uca_valid  in  NUM_ENGINE  per-engine head valid.
eng2uca_empty  in  NUM_ENGINE  per-engine queue empty; a head is ignored when its empty bit is set.
eng2uca_full  in  NUM_ENGINE  per-engine queue full; acts as backpressure.
uca2eng  out  LW signed  broadcast literal (FIFO head, 0 when empty).
input_mode  in  1  1 = memory source enabled.
uca2eng_pop  out  1  uca2eng is valid and is being dequeued this cycle.
conflict  out  1  sticky conflict flag.

Behaviour:
- Reset (rst=0, async): FIFO empty, assignment table cleared, done latch 0, round-robin pointer 0, conflict 0. Outputs: uca2eng=0, uca2eng_pop=0.
- At most one push per cycle. Source selection:
  - Memory source when input_mode=1, mem2uca_valid=1 and the done latch is 0.
  - Otherwise the engine source: the grant goes to the first engine i with eng2uca_valid[i]=1 and eng2uca_empty[i]=0, searching from the RR pointer upward with wrap. On a grant, the pointer moves to i+1 mod NUM_ENGINE.
  - The done latch sets on mem2uca_done=1.
- Candidate literal L=0 is ignored.
- Assignment table: one entry per variable |L|, holding {assigned, sign}.
  - |L| unassigned: push L and mark the entry (assigned=1, sign=sign(L)).
  - Same polarity already assigned: drop L (duplicate). This prevents engines that hold a head for several cycles from enqueuing it repeatedly.
  - Opposite polarity assigned: conflict sets on the next edge; L is not pushed.
- FIFO full with no pop this cycle: push is refused and the table is not updated, so an engine literal retries later. A memory literal is lost in this case; the loader must not send more than QUEUE_DEPTH literals before draining.
- A push and a pop in the same cycle are legal, including when the FIFO is full.
- Pop is combinational: uca2eng_pop = FIFO non-empty AND no eng2uca_full bit set AND conflict=0. The head is dequeued on the edge where uca2eng_pop=1.
- uca2eng = FIFO head when non-empty, else 0.
- Latency: a literal pushed at edge N appears on uca2eng after edge N and can pop in that cycle.
- Once conflict=1 it stays 1, pushes and pops stop, and the FIFO contents freeze until reset.
- Reset mid-operation discards all queued literals and table state immediately.

Optional Feature:
UCA_ROUND_ROBIN_EN.
- Defined: engine grant is round-robin as described above.
- Undefined: fixed priority, lowest valid engine index wins, and no pointer register exists.
- Dedup keeps both variants starvation-free for held heads.

Decomposition:
- Shared package uca_pkg: typedef lit_t (signed LW bits), constants NUM_ENGINE, LIT_IDX_MAX, QUEUE_DEPTH, and function lit_var(L) returning |L|.
- One sub-module, uca_fifo: synchronous FIFO of lit_t with push/pop/full/empty and async active-low reset.
- Arbitration and the assignment table stay in the top level.

Test Plan:
- Reset then memory burst: input_mode=1, mem2uca=10,20,30,40,50 on consecutive cycles, then done=1. uca2eng_pop pulses 5 times, uca2eng=10,20,30,40,50 in order, then uca2eng=0 and pop=0.
- Engine heads: after done, eng2uca_min[1]=3 and eng2uca_min[3]=5 with valid, held 4 cycles. Each is enqueued exactly once, 3 then 5; afterwards pop=0.
- Full stall: queue holds 60, eng2uca_full[2]=1 for 5 cycles. uca2eng_pop=0 and uca2eng=60 throughout; after clearing full, one pop of 60.
- Conflict: memory sends 7, an engine later offers -7. conflict=1 on the next cycle, -7 is never broadcast, conflict stays 1 until rst=0.
- Overflow and simultaneous traffic: fill 16 literals with full asserted, offer a 17th engine literal 99 (refused). Release full: 99 is accepted on the first pop cycle.
- Async reset mid-burst: drop rst low between edges. uca2eng=0, pop=0 and conflict=0 immediately, and the FIFO is empty after release.
